// File: rtl/digitally_controlled_oscillator.sv
// Half-period counting clock synthesiser: a HIGH/LOW down-counter square wave
// with a valid/ready one-shot phase correction applied at rising-edge boundaries.

module digitally_controlled_oscillator #(
    parameter int WIDTH    = 8,
    parameter int MIN_HALF = 2
) (
    input  logic             fpga_clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] half_period_i,
    input  logic [WIDTH-1:0] phase_adj_i,
    input  logic             phase_adj_valid_i,
    output logic             phase_adj_ready_o,
    output logic             generated_o,
    output logic             rise_o,
    output logic [WIDTH-1:0] half_period_o
);

    localparam int EXT_W = WIDTH + 2;
    localparam logic [WIDTH-1:0] MIN_HALF_W = WIDTH'(MIN_HALF);
    localparam logic [WIDTH-1:0] ONE_W      = WIDTH'(1);
    localparam logic signed [EXT_W-1:0] MIN_EXT = $signed({2'b00, MIN_HALF_W});
    localparam logic signed [EXT_W-1:0] MAX_EXT = $signed({2'b00, {WIDTH{1'b1}}});

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    // Corrected high length: L + sext(adj) at WIDTH+2 bits, clamped to the legal range.
    function automatic logic [WIDTH-1:0] corrected_high(
        input logic [WIDTH-1:0] l_word,
        input logic [WIDTH-1:0] adj
    );
        logic signed [EXT_W-1:0] sum;
        sum = $signed({2'b00, l_word}) + $signed({{2{adj[WIDTH-1]}}, adj});
        if (sum < MIN_EXT) begin
            corrected_high = MIN_HALF_W;
        end else if (sum > MAX_EXT) begin
            corrected_high = {WIDTH{1'b1}};
        end else begin
            corrected_high = sum[WIDTH-1:0];
        end
    endfunction

    state_t           state_r,     state_s;
    logic [WIDTH-1:0] count_r,     count_s;
    logic             generated_r, generated_s;
    logic             rise_r,      rise_s;
    logic [WIDTH-1:0] half_r,      half_s;
    logic             pending_r,   pending_s;
    logic [WIDTH-1:0] adj_r,       adj_s;
    logic [WIDTH-1:0] l_word_s;
    logic [WIDTH-1:0] h_word_s;
    logic             boundary_s;
    logic             accept_s;

    // Lengths for a period that would start at this edge.
    always_comb begin
        l_word_s = half_period_i;
        h_word_s = half_period_i;
        if (half_period_i < MIN_HALF_W) begin
            l_word_s = MIN_HALF_W;
        end else begin
            l_word_s = half_period_i;
        end
        if (pending_r) begin
            h_word_s = corrected_high(l_word_s, adj_r);
        end else begin
            h_word_s = l_word_s;
        end
    end

    // Phase sequencing. Leaving IDLE passes through a one-cycle LOW so the first
    // rising edge reuses the ordinary end-of-LOW boundary.
    always_comb begin
        state_s     = state_r;
        count_s     = count_r;
        generated_s = generated_r;
        rise_s      = 1'b0;
        half_s      = half_r;
        boundary_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                generated_s = 1'b0;
                if (enable_i) begin
                    state_s = ST_LOW;
                    count_s = ONE_W;
                end else begin
                    state_s = ST_IDLE;
                    count_s = '0;
                end
            end
            ST_HIGH: begin
                if (count_r <= ONE_W) begin
                    state_s     = ST_LOW;
                    count_s     = half_r;
                    generated_s = 1'b0;
                end else begin
                    count_s = count_r - ONE_W;
                end
            end
            ST_LOW: begin
                if (count_r > ONE_W) begin
                    count_s = count_r - ONE_W;
                end else if (enable_i) begin
                    boundary_s  = 1'b1;
                    state_s     = ST_HIGH;
                    count_s     = h_word_s;
                    generated_s = 1'b1;
                    rise_s      = 1'b1;
                    half_s      = l_word_s;
                end else begin
                    state_s     = ST_IDLE;
                    count_s     = '0;
                    generated_s = 1'b0;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                count_s     = '0;
                generated_s = 1'b0;
            end
        endcase
    end

    // Correction slot: a boundary consumes with the old flag, so a same-edge accept waits a period.
    always_comb begin
        accept_s  = phase_adj_valid_i & ~pending_r;
        pending_s = pending_r;
        adj_s     = adj_r;
        if (accept_s) begin
            pending_s = 1'b1;
            adj_s     = phase_adj_i;
        end else if (boundary_s) begin
            pending_s = 1'b0;
        end else begin
            pending_s = pending_r;
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge fpga_clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_r     <= ST_IDLE;
            count_r     <= '0;
            generated_r <= 1'b0;
            rise_r      <= 1'b0;
            half_r      <= MIN_HALF_W;
            pending_r   <= 1'b0;
            adj_r       <= '0;
        end else begin
            state_r     <= state_s;
            count_r     <= count_s;
            generated_r <= generated_s;
            rise_r      <= rise_s;
            half_r      <= half_s;
            pending_r   <= pending_s;
            adj_r       <= adj_s;
        end
    end

    assign generated_o       = generated_r;
    assign rise_o            = rise_r;
    assign half_period_o     = half_r;
    assign phase_adj_ready_o = ~pending_r;

endmodule

// File: tb/tb_digitally_controlled_oscillator.sv
// Directed bench for digitally_controlled_oscillator: a period-level reference
// model compared every cycle, plus hand-computed phase-length expectations.

module tb_digitally_controlled_oscillator;

    localparam int MINH = 2;

    logic       clk = 1'b0;
    logic       reset_i = 1'b0;
    logic       enable_i = 1'b0;
    logic [7:0] half_period_i = 8'd0;
    logic [7:0] phase_adj_i = 8'd0;
    logic       phase_adj_valid_i = 1'b0;
    logic       phase_adj_ready_o;
    logic       generated_o;
    logic       rise_o;
    logic [7:0] half_period_o;

    int total = 0;
    int passes = 0;

    digitally_controlled_oscillator #(.WIDTH(8), .MIN_HALF(MINH)) dut (
        .fpga_clk_i(clk),
        .reset_i(reset_i),
        .enable_i(enable_i),
        .half_period_i(half_period_i),
        .phase_adj_i(phase_adj_i),
        .phase_adj_valid_i(phase_adj_valid_i),
        .phase_adj_ready_o(phase_adj_ready_o),
        .generated_o(generated_o),
        .rise_o(rise_o),
        .half_period_o(half_period_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: position within the current period, counting up.
    bit         m_run = 1'b0, m_arm = 1'b0, m_pend = 1'b0;
    int         m_pos = 0, m_h = 0, m_l = 0, m_hp = MINH;
    logic [7:0] m_adj = 8'd0;

    task automatic m_start();
        int l, s;
        l = (int'(half_period_i) < MINH) ? MINH : int'(half_period_i);
        if (m_pend) begin
            s = l + (m_adj[7] ? int'(m_adj) - 256 : int'(m_adj));
            m_h = (s < MINH) ? MINH : ((s > 255) ? 255 : s);
        end else begin
            m_h = l;
        end
        m_l = l; m_hp = l; m_pend = 1'b0; m_pos = 0; m_run = 1'b1;
    endtask

    always @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            m_run = 1'b0; m_arm = 1'b0; m_pend = 1'b0; m_pos = 0; m_hp = MINH;
        end else begin
            bit acc;
            acc = phase_adj_valid_i && !m_pend;
            if (m_run) begin
                m_pos++;
                if (m_pos == m_h + m_l) begin
                    m_run = 1'b0;
                    if (enable_i) m_start();
                end
            end else if (m_arm) begin
                m_arm = 1'b0;
                if (enable_i) m_start();
            end else if (enable_i) begin
                m_arm = 1'b1;
            end
            if (acc) begin
                m_pend = 1'b1;
                m_adj = phase_adj_i;
            end
        end
    end

    always @(negedge clk) begin
        check("model_generated", int'(generated_o), int'(m_run && m_pos < m_h));
        check("model_rise", int'(rise_o), int'(m_run && m_pos == 0));
        check("model_ready", int'(phase_adj_ready_o), int'(!m_pend));
        check("model_half", int'(half_period_o), m_hp);
    end

    task automatic drive_offer(input int t, input int off_at, input int off_len,
                               input logic [7:0] v1, input logic [7:0] v2);
        if (off_at >= 0 && t >= off_at && t < off_at + off_len) begin
            phase_adj_valid_i = 1'b1;
            phase_adj_i = (t == off_at) ? v1 : v2;
        end else begin
            phase_adj_valid_i = 1'b0;
        end
    endtask

    // Entered at the negedge where rise_o is seen; returns at the next one.
    task automatic measure(output int h, output int l, output int hp,
                           input int off_at = -1, input int off_len = 1,
                           input logic [7:0] v1 = 8'd0, input logic [7:0] v2 = 8'd0);
        int t;
        bit done;
        hp = int'(half_period_o);
        h = 1; l = 0; t = 0; done = 1'b0;
        drive_offer(t, off_at, off_len, v1, v2);
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clk); t++;
            drive_offer(t, off_at, off_len, v1, v2);
            if (generated_o) h++;
            else begin l = 1; done = 1'b1; end
        end
        done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clk); t++;
            drive_offer(t, off_at, off_len, v1, v2);
            if (rise_o) done = 1'b1;
            else l++;
        end
        phase_adj_valid_i = 1'b0;
        if (!done) check("measure_timeout", 0, 1);
    endtask

    task automatic wait_rise();
        bit ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (rise_o) ok = 1'b1;
        end
        check("wait_rise_timeout", int'(ok), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int h, l, hp, rises;
        // Reset state
        @(negedge clk);
        check("rst_generated", int'(generated_o), 0);
        check("rst_ready", int'(phase_adj_ready_o), 1);
        check("rst_half", int'(half_period_o), 2);
        @(negedge clk);
        reset_i = 1'b1;
        // 1. Steady run, first high one cycle after enable is sampled
        half_period_i = 8'd4;
        enable_i = 1'b1;
        @(negedge clk);
        check("t1_latency_low", int'(generated_o), 0);
        @(negedge clk);
        check("t1_first_high", int'(generated_o), 1);
        check("t1_first_rise", int'(rise_o), 1);
        measure(h, l, hp);
        check("t1_h", h, 4); check("t1_l", l, 4); check("t1_hp", hp, 4);
        // 2. Clamping of 0 and 1, then mid-HIGH change 4 -> 6
        half_period_i = 8'd0;
        measure(h, l, hp);
        check("t2_cur_h", h, 4); check("t2_cur_l", l, 4);
        half_period_i = 8'd1;
        measure(h, l, hp);
        check("t2_zero_h", h, 2); check("t2_zero_l", l, 2); check("t2_zero_hp", hp, 2);
        measure(h, l, hp);
        check("t2_one_h", h, 2); check("t2_one_l", l, 2); check("t2_one_hp", hp, 2);
        half_period_i = 8'd4;
        measure(h, l, hp);
        half_period_i = 8'd6;
        measure(h, l, hp);
        check("t2_keep_h", h, 4); check("t2_keep_l", l, 4);
        half_period_i = 8'd5;
        measure(h, l, hp);
        check("t2_six_h", h, 6); check("t2_six_l", l, 6); check("t2_six_hp", hp, 6);
        // 3. Positive correction; the +50 re-offer while ready is low must be ignored
        measure(h, l, hp, 0, 3, 8'd3, 8'd50);
        check("t3_pre_h", h, 5); check("t3_pre_l", l, 5);
        check("t3_ready_after_boundary", int'(phase_adj_ready_o), 1);
        measure(h, l, hp);
        check("t3_corr_h", h, 8); check("t3_corr_l", l, 5);
        // 4. Negative correction clamps to MIN_HALF
        measure(h, l, hp, 0, 1, 8'hF6, 8'h00);
        check("t3_resume_h", h, 5); check("t3_resume_l", l, 5);
        half_period_i = 8'd255;
        measure(h, l, hp, 0, 1, 8'd127, 8'd0);
        check("t4_neg_h", h, 2); check("t4_neg_l", l, 5);
        half_period_i = 8'd4;
        measure(h, l, hp);
        check("t4_ovf_h", h, 255); check("t4_ovf_l", l, 255); check("t4_ovf_hp", hp, 255);
        // Correction accepted on the boundary edge applies one period later
        measure(h, l, hp, 7, 1, 8'd2, 8'd0);
        check("t4_bnd_cur_h", h, 4);
        check("t4_bnd_ready", int'(phase_adj_ready_o), 0);
        measure(h, l, hp);
        check("t4_bnd_next_h", h, 4); check("t4_bnd_next_l", l, 4);
        measure(h, l, hp);
        check("t4_bnd_late_h", h, 6); check("t4_bnd_late_l", l, 4);
        // 5. Enable drop mid-HIGH, correction accepted while idle
        enable_i = 1'b0;
        h = 1; rises = 0;
        repeat (40) begin
            @(negedge clk);
            if (generated_o) h++;
            if (rise_o) rises++;
        end
        check("t5_full_high", h, 4);
        check("t5_no_rise", rises, 0);
        check("t5_idle_low", int'(generated_o), 0);
        phase_adj_i = 8'd1; phase_adj_valid_i = 1'b1;
        @(negedge clk);
        phase_adj_valid_i = 1'b0;
        check("t5_idle_accept", int'(phase_adj_ready_o), 0);
        repeat (3) @(negedge clk);
        enable_i = 1'b1;
        wait_rise();
        measure(h, l, hp);
        check("t5_reen_h", h, 5); check("t5_reen_l", l, 4); check("t5_reen_hp", hp, 4);
        // 6. Asynchronous reset mid-HIGH with a correction pending
        phase_adj_i = 8'd5; phase_adj_valid_i = 1'b1;
        @(negedge clk);
        phase_adj_valid_i = 1'b0;
        check("t6_pending", int'(phase_adj_ready_o), 0);
        #2 reset_i = 1'b0;
        #1;
        check("t6_async_gen", int'(generated_o), 0);
        check("t6_async_rise", int'(rise_o), 0);
        check("t6_async_ready", int'(phase_adj_ready_o), 1);
        check("t6_async_half", int'(half_period_o), 2);
        @(negedge clk);
        reset_i = 1'b1;
        wait_rise();
        measure(h, l, hp);
        check("t6_restart_h", h, 4); check("t6_restart_l", l, 4); check("t6_restart_hp", hp, 4);
        enable_i = 1'b0;
        repeat (12) @(negedge clk);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
